w0rm_core_fetch: RTL and testbench

- Instruction fetch stage at the head of the W0RM core pipeline.
- Owns the program counter and issues one instruction-memory read at a time.
- Passes each fetched instruction and its address to decode over a valid/ready handshake.
- Consumes the branch stage's next_pc / next_pc_valid (flush) redirect, discarding any wrong-path fetch in flight.

---
 rtl/w0rm_core_fetch_pkg.sv | 14 +
 rtl/w0rm_core_fetch.sv | 101 ++++++++++
 tb/tb_w0rm_core_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_core_fetch_pkg.sv
// Shared W0RM core definitions: fetch-stage state encoding and the sequential
// instruction stride, which the branch stage also uses for its +2 arithmetic.
package w0rm_core_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 2;

endpackage

// File: rtl/w0rm_core_fetch.sv
// W0RM instruction fetch: owns the PC, keeps at most one imem read in flight,
// and hands each instruction to decode over valid/ready; next_pc_valid flushes.
module w0rm_core_fetch
    import w0rm_core_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           INST_BYTES = w0rm_core_fetch_pkg::INST_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    input  logic                  next_pc_valid,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_rvalid,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  decode_ready
);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  hold;

    assign hold = (state_q == FETCH_HOLD);

    // A redirect overrides the sequential increment in every state.
    always_comb begin
        pc_d = pc_q;
        if (next_pc_valid) begin
            pc_d = next_pc;
        end else if (state_q == FETCH_REQ && imem_ack) begin
            pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values; the payload registers are reset too, because decode
    // and the bench rely on inst_out/inst_pc reading zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            inst_pc_q <= '0;
            inst_q    <= '0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                FETCH_REQ: begin
                    if (imem_ack) begin
                        req_pc_q <= pc_q;
                        // An accepted read in a redirect cycle is already wrong-path.
                        state_q  <= next_pc_valid ? FETCH_DROP : FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (next_pc_valid) begin
                            state_q <= FETCH_REQ;
                        end else begin
                            inst_q    <= imem_rdata;
                            inst_pc_q <= req_pc_q;
                            state_q   <= FETCH_HOLD;
                        end
                    end else if (next_pc_valid) begin
                        state_q <= FETCH_DROP;
                    end
                end
                FETCH_HOLD: begin
                    if (next_pc_valid || decode_ready) begin
                        state_q <= FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    // The stale read retires here; a coincident redirect only moves pc.
                    if (imem_rvalid) begin
                        state_q <= FETCH_REQ;
                    end
                end
                default: state_q <= FETCH_REQ;
            endcase
        end
    end

    assign imem_req   = (state_q == FETCH_REQ) && !reset;
    assign imem_addr  = pc_q;
    assign inst_out   = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = hold && !next_pc_valid;

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Directed plus randomized bench for w0rm_core_fetch against a memory model and
// an instruction-stream reference (sequential +2 stream, restarted by redirect/reset).
module tb_w0rm_core_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic [15:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        decode_ready;

    always #5 clk = ~clk;

    w0rm_core_fetch #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (16),
        .RESET_PC   (RST_PC),
        .INST_BYTES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .next_pc       (next_pc),
        .next_pc_valid (next_pc_valid),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .decode_ready  (decode_ready)
    );

    int n_checks;
    int n_fails;

    // memory model state and knobs
    logic        pend_valid;
    int          pend_delay;
    logic [31:0] pend_addr;
    int unsigned ack_pct;
    int unsigned dly_min;
    int unsigned dly_max;

    // reference: next address the fetcher must request, next address decode must see
    logic [31:0] fetch_pc;
    logic [31:0] exp_pc;
    int          n_acc;
    logic [31:0] last_acc_pc;
    int          idle;

    // values sampled in the previous cycle
    logic        s_valid;
    logic        s_req;
    logic        s_ack;
    logic        s_hold_pending;
    logic        after_reset;
    logic [31:0] s_pc;
    logic [15:0] s_inst;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: entered at posedge+1, drives inputs, samples at negedge, returns at posedge+1.
    task automatic cycle(input logic r, input logic redir, input logic [31:0] tgt, input logic ready);
        logic ack_now;
        logic rv_now;
        reset         = r;
        next_pc_valid = redir;
        next_pc       = tgt;
        decode_ready  = ready;
        rv_now        = !r && pend_valid && pend_delay == 0;
        imem_rvalid   = rv_now;
        imem_rdata    = rv_now ? mem_word(pend_addr) : 16'($urandom);
        imem_ack      = 1'b0;
        #1;
        ack_now  = imem_req && ($urandom_range(0, 99) < ack_pct);
        imem_ack = ack_now;
        #3;

        if (after_reset) begin
            check("rst_inst_valid", 32'(inst_valid), 0);
            check("rst_inst_out", 32'(inst_out), 0);
            check("rst_inst_pc", inst_pc, 0);
            check("rst_pc", imem_addr, RST_PC);
        end
        if (r) check("req_in_reset", 32'(imem_req), 0);
        check("req_while_busy", 32'(imem_req && pend_valid), 0);
        if (imem_req) check("imem_addr", imem_addr, fetch_pc);
        if (redir) check("valid_masked", 32'(inst_valid), 0);
        if (s_hold_pending && !r) begin
            check("hold_pc", inst_pc, s_pc);
            check("hold_inst", 32'(inst_out), 32'(s_inst));
            check("hold_valid", 32'(inst_valid), 32'(!redir));
            check("hold_no_req", 32'(imem_req), 0);
        end
        if (!r && inst_valid && ready) begin
            check("acc_pc", inst_pc, exp_pc);
            check("acc_inst", 32'(inst_out), 32'(mem_word(exp_pc)));
            n_acc++;
            last_acc_pc = inst_pc;
            exp_pc      = exp_pc + 32'd2;
            idle        = 0;
        end else begin
            idle++;
        end
        if (idle > 200) begin
            check("progress_timeout", 32'(idle), 0);
            idle = 0;
        end

        if (r) begin
            pend_valid = 1'b0;
            fetch_pc   = RST_PC;
            exp_pc     = RST_PC;
        end else begin
            if (rv_now) pend_valid = 1'b0;
            else if (pend_valid) pend_delay--;
            if (ack_now) begin
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_delay = int'($urandom_range(dly_min, dly_max));
            end
            if (redir) begin
                fetch_pc = tgt;
                exp_pc   = tgt;
            end else if (ack_now) begin
                fetch_pc = fetch_pc + 32'd2;
            end
        end
        s_valid        = inst_valid;
        s_req          = imem_req;
        s_ack          = ack_now;
        s_hold_pending = !r && inst_valid && !ready;
        s_pc           = inst_pc;
        s_inst         = inst_out;
        after_reset    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !s_hold_pending; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("wait_valid_timeout", 32'(s_hold_pending), 1);
    endtask

    task automatic wait_outstanding();
        for (int i = 0; i < 50 && !(pend_valid && pend_delay > 0); i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("wait_outstanding_timeout", 32'(pend_valid && pend_delay > 0), 1);
    endtask

    initial begin
        logic        rd;
        logic [31:0] tg;
        n_checks = 0;        n_fails = 0;
        reset = 1'b1;        next_pc_valid = 1'b0; next_pc = '0;   decode_ready = 1'b0;
        imem_ack = 1'b0;     imem_rvalid = 1'b0;   imem_rdata = '0;
        pend_valid = 1'b0;   pend_delay = 0;       pend_addr = '0;
        ack_pct = 100;       dly_min = 0;          dly_max = 0;
        fetch_pc = RST_PC;   exp_pc = RST_PC;      n_acc = 0;      last_acc_pc = '0; idle = 0;
        s_valid = 1'b0;      s_req = 1'b0;         s_ack = 1'b0;   s_hold_pending = 1'b0;
        after_reset = 1'b0;  s_pc = '0;            s_inst = '0;
        @(posedge clk);
        #1;

        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0);

        // first instruction appears on the 3rd cycle after reset with 1-cycle memory
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("lat_c1_req", 32'(s_req), 1);
        check("lat_c1_valid", 32'(s_valid), 0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("lat_c2_req", 32'(s_req), 0);
        check("lat_c2_valid", 32'(s_valid), 0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("lat_c3_valid", 32'(s_valid), 1);
        check("first_pc", last_acc_pc, RST_PC);

        // back-pressure on 0x102
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            check("bp_valid", 32'(s_valid), 1);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("bp_accept_pc", last_acc_pc, RST_PC + 32'd2);

        // redirect while the read of 0x104 is still outstanding
        dly_min = 2; dly_max = 2;
        wait_outstanding();
        check("wait_addr", pend_addr, RST_PC + 32'd4);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        wait_valid();
        check("redir_wait_pc", s_pc, 32'h0000_0200);

        // redirect in HOLD with decode_ready in the same cycle
        cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        check("hold_redir_valid", 32'(s_valid), 0);
        wait_valid();
        check("hold_redir_pc", s_pc, 32'h0000_0300);
        ack_pct = 0;
        cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // redirect coincident with imem_ack
        for (int i = 0; i < 10 && !s_req; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        ack_pct = 100;
        cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        check("coinc_ack_taken", 32'(s_ack), 1);
        wait_valid();
        check("coinc_pc", s_pc, 32'h0000_0400);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        wait_valid();
        check("wrap_pc_top", s_pc, 32'hFFFF_FFFE);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        wait_valid();
        check("wrap_pc_zero", s_pc, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // reset while a read is outstanding
        wait_outstanding();
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("post_rst_req", 32'(s_req), 1);

        // randomized traffic
        ack_pct = 70; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 99) < 4);
            tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h6))
                                             : ($urandom & 32'hFFFF_FFFE);
            cycle(($urandom_range(0, 499) == 0), rd, tg, ($urandom_range(0, 99) < 65));
        end
        check("random_progress", 32'(n_acc > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
